// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round constants and xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StValid,
    StExpand,
    StDone
  } aes_state_e;

  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1b;
  localparam int unsigned AES_ROUNDS = 10;

  // Multiply by x in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sBox.sv
// AES forward S-box, purely combinational byte substitution.
module sBox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Byte n of the table is the substitution for input value n.
  localparam logic [0:2047] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SboxTable[{data_i, 3'b000} +: 8];

endmodule

// File: rtl/key_expander.sv
// AES-128 round-key generator: presents one round key at a time, expanding the
// next one on demand when the consumer accepts the current key.
module key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [0:127] cipher_key,
  input  logic         rk_req,
  output logic [0:127] round_key,
  output logic [3:0]   round_num,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  aes_state_e   state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] rot_w3, sub_w3, temp;
  logic [0:31] n0, n1, n2, n3;

  assign w0 = key_q[0:31];
  assign w1 = key_q[32:63];
  assign w2 = key_q[64:95];
  assign w3 = key_q[96:127];

  assign rot_w3 = {w3[8:31], w3[0:7]};

  // S-boxes read the registered w3, so the whole expansion is reg-to-reg.
  for (genvar g = 0; g < 4; g++) begin : gen_sbox
    sBox u_sbox (
      .data_i (rot_w3[8*g +: 8]),
      .data_o (sub_w3[8*g +: 8])
    );
  end

  assign temp = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    rcon_d  = rcon_q;
    if (key_load) begin
      state_d = StValid;
      key_d   = cipher_key;
      num_d   = 4'd0;
      rcon_d  = RCON_INIT;
    end else begin
      unique case (state_q)
        StValid: begin
          if (rk_req) state_d = (num_q == 4'(AES_ROUNDS)) ? StDone : StExpand;
        end
        StExpand: begin
          key_d   = {n0, n1, n2, n3};
          num_d   = num_q + 4'd1;
          rcon_d  = xtime(rcon_q);
          state_d = StValid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      num_q   <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      rcon_q  <= rcon_d;
    end
  end

  assign round_key = key_q;
  assign round_num = num_q;
  assign rk_valid  = (state_q == StValid);
  assign busy      = (state_q == StValid) || (state_q == StExpand);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: directed scenarios plus random keys, checked against a
// key schedule computed from GF(2^8) arithmetic.
module tb_key_expander;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_load;
  logic [0:127] cipher_key;
  logic         rk_req;
  logic [0:127] round_key;
  logic [3:0]   round_num;
  logic         rk_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] sched  [11];

  always #5 clk = ~clk;

  key_expander dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .rk_req     (rk_req),
    .round_key  (round_key),
    .round_num  (round_num),
    .rk_valid   (rk_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] st(input logic v, input logic b, input logic d,
                                      input int n);
    return {121'd0, v, b, d, 4'(n)};
  endfunction

  function automatic logic [127:0] obs();
    return {121'd0, rk_valid, busy, done, round_num};
  endfunction

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p ^= a;
      a = a << 1;
      if (a > 255) a ^= 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s;
      for (int i = 1; i < 256 && x != 0; i++) if (gmul(x, i) == 1) inv = i;
      s = inv;
      for (int r = 1; r <= 4; r++) s ^= ((inv << r) | (inv >> (8 - r))) & 'hff;
      sbox_t[x] = 8'(s ^ 'h63);
    end
  endtask

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    int rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t ^= {rc[7:0], 24'h0};
        rc = rc * 2;
        if (rc > 255) rc ^= 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) sched[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic load(input logic [127:0] key, input logic req);
    cipher_key = key;
    key_load   = 1'b1;
    rk_req     = req;
    tick();
    key_load = 1'b0;
    rk_req   = 1'b0;
    build_schedule(key);
  endtask

  // Consumer walks from round `start` (currently valid) through to DONE.
  task automatic walk(input int start);
    for (int k = start; k <= 10; k++) begin
      chk("valid_status", obs(), st(1, 1, 0, k));
      chk("valid_key", round_key, sched[k]);
      repeat ($urandom_range(0, 2)) begin
        rk_req = 1'b0;
        tick();
        chk("hold_key", round_key, sched[k]);
        chk("hold_status", obs(), st(1, 1, 0, k));
      end
      rk_req = 1'b1;
      tick();
      rk_req = 1'($urandom_range(0, 1));
      if (k < 10) begin
        chk("expand_status", obs(), st(0, 1, 0, k));
        tick();
        rk_req = 1'b0;
      end else begin
        chk("done_status", obs(), st(0, 0, 1, 10));
        chk("done_key", round_key, sched[10]);
        repeat (3) begin
          rk_req = 1'($urandom_range(0, 1));
          tick();
          chk("done_hold_status", obs(), st(0, 0, 1, 10));
          chk("done_hold_key", round_key, sched[10]);
        end
        rk_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic [127:0] ka, kb;
    build_sbox();

    n_rst      = 1'b0;
    key_load   = 1'b1;
    rk_req     = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    chk("reset_status", obs(), st(0, 0, 0, 0));
    chk("reset_key", round_key, 128'h0);

    n_rst    = 1'b1;
    key_load = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_req_status", obs(), st(0, 0, 0, 0));
      chk("idle_req_key", round_key, 128'h0);
    end
    rk_req = 1'b0;

    // FIPS-197 example key.
    load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    chk("fips_r0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    chk("fips_expand", obs(), st(0, 1, 0, 0));
    tick();
    chk("fips_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    walk(1);
    chk("fips_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    load(128'h0, 1'b0);
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    tick();
    chk("zero_r1", round_key, 128'h62636363626363636263636362636363);
    walk(1);
    chk("zero_r10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Continuous request: one key every two cycles.
    load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    rk_req = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (c < 21) begin
        chk("stream_status", obs(), st((c % 2) == 0, 1, 0, c / 2));
        if (c % 2 == 0) chk("stream_key", round_key, sched[c/2]);
      end else begin
        chk("stream_done", obs(), st(0, 0, 1, 10));
      end
      tick();
    end
    rk_req = 1'b0;

    // Reload at round 5 with a simultaneous request.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    load(ka, 1'b0);
    repeat (5) begin
      rk_req = 1'b1;
      tick();
      rk_req = 1'b0;
      tick();
    end
    chk("r5_status", obs(), st(1, 1, 0, 5));
    chk("r5_key", round_key, sched[5]);
    load(kb, 1'b1);
    chk("reload_status", obs(), st(1, 1, 0, 0));
    chk("reload_key", round_key, kb);
    walk(0);

    // Reload while expanding.
    load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    rk_req = 1'b1;
    tick();
    ka = {$urandom, $urandom, $urandom, $urandom};
    load(ka, 1'b0);
    chk("reload_expand_status", obs(), st(1, 1, 0, 0));
    chk("reload_expand_key", round_key, ka);

    // Reset during EXPAND discards progress.
    rk_req = 1'b1;
    tick();
    chk("pre_reset_expand", obs(), st(0, 1, 0, 0));
    n_rst  = 1'b0;
    rk_req = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mid_reset_status", obs(), st(0, 0, 0, 0));
    chk("mid_reset_key", round_key, 128'h0);
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    chk("post_reset_idle", obs(), st(0, 0, 0, 0));
    load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    walk(0);

    repeat (3) begin
      load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      walk(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 (10 rounds, 128-bit key).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-low.
REQ-004 key_load  input  1  single-cycle pulse; captures cipher_key and restarts the schedule.
REQ-005 cipher_key  input  128  declared [0:127]; byte 0 is bits [0:7], word w0 is bits [0:31].
REQ-006 rk_req  input  1  consumer accepts the presented round key; acts only when rk_valid=1.
REQ-007 round_key  output  128  current round key, declared [0:127], same byte order as cipher_key.
REQ-008 round_num  output  4  index of round_key, 0..10.
REQ-009 rk_valid  output  1  round_key and round_num are valid.
REQ-010 busy  output  1  high in VALID and EXPAND states.
REQ-011 done  output  1  high in DONE state (all 11 keys consumed).

Function
REQ-012 FSM states SHALL be IDLE, VALID, EXPAND and DONE.
REQ-013 key_load in any state SHALL, on the next edge, load round_key=cipher_key, round_num=0 and rcon=8'h01, and SHALL enter VALID; this restarts any schedule in progress.
REQ-014 In VALID, rk_valid=1; rk_req=1 with round_num<10 SHALL enter EXPAND; rk_req=1 with round_num=10 SHALL enter DONE.
REQ-015 EXPAND SHALL last exactly one cycle with rk_valid=0. On exit: round_key=next key, round_num+1, rcon=xtime(rcon), then return to VALID.
REQ-016 Next key: temp=SubWord(RotWord(w3)) xor {rcon,8'h00,8'h00,8'h00}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-017 RotWord SHALL rotate bytes {a,b,c,d} to {b,c,d,a}. SubWord SHALL apply the AES S-box to each of the 4 bytes.
REQ-018 rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36. xtime is a left shift by 1, xor 8'h1b if the shifted-out MSB was 1.
REQ-019 The S-box inputs SHALL be driven from a registered w3, so the S-box path is register-to-register within EXPAND.
REQ-020 Accept-to-next-key latency SHALL be 2 cycles: the rk_req edge, then the EXPAND edge.
REQ-021 rk_req SHALL be ignored in IDLE, EXPAND and DONE.
REQ-022 In DONE, rk_valid=0 and done=1; round_key and round_num SHALL hold round-10 values until key_load.
REQ-023 If key_load and rk_req are high in the same cycle, key_load SHALL win.

Reset
REQ-024 n_rst=0 at an edge SHALL force IDLE, round_key=0, round_num=0, rcon=8'h01, rk_valid=0, busy=0 and done=0, regardless of key_load.
REQ-025 Reset mid-schedule SHALL discard all progress; a new key_load is required to restart.

Structure
REQ-026 A shared package aes_pkg SHALL hold the FSM state enum, the RCON_INIT constant (8'h01), the xtime reduction constant (8'h1b) and the AES_ROUNDS constant (10).
REQ-027 SubWord SHALL instantiate the existing sBox sub-module four times, one per byte of the rotated w3.
REQ-028 The block SHALL contain no other sub-modules.

Verification
REQ-029 Reset, then key_load with key 2b7e151628aed2a6abf7158809cf4f3c -> round 0 equals the key; after one accept, round 1 = a0fafe1788542cb123a339392a6c7605.
REQ-030 Same key, 10 accepts -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; the 11th accept -> done=1, rk_valid=0.
REQ-031 All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 rk_req held high continuously -> rk_valid alternates 1,0 each cycle, round_num increments every 2 cycles; rk_req in IDLE has no effect.
REQ-033 key_load at round 5 with a new key -> next cycle round_num=0 and round_key equals the new key; a simultaneous rk_req is ignored.
REQ-034 n_rst=0 asserted during EXPAND -> next edge gives IDLE with all outputs 0; a subsequent key_load restarts the schedule correctly.
